fazyrv_ram_arb: RTL and testbench

- Two-requester arbiter and sequencer in front of the FazyRV single-port SoC RAM (32-bit words; each cycle is one read or one write; read data is registered).
- Presents two Wishbone-classic word-addressed slave ports (A, B), arbitrated round-robin.
- Serialises accesses into RAM read/write cycles and performs read-modify-write for partial byte-select writes, since the RAM has no byte enables.

---
 rtl/fazyrv_ram_arb_pkg.sv | 28 ++
 rtl/fazyrv_rr_arb2.sv | 27 ++
 rtl/fazyrv_ram_arb.sv | 132 +++++++++++++
 tb/tb_fazyrv_ram_arb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fazyrv_ram_arb_pkg.sv
// Shared types and helpers for the two-port RAM arbiter/sequencer.
package fazyrv_ram_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_MERGE = 3'd2,
        S_WR    = 3'd3,
        S_RSP   = 3'd4,
        S_ACK   = 3'd5
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Bytes with sel set come from the requester, the rest keep the RAM contents.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/fazyrv_rr_arb2.sv
// Two-way round-robin grant; the last-grant register only advances when en is high.
module fazyrv_rr_arb2
    import fazyrv_ram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic       en,
    output logic       gnt,
    output logic       gnt_vld
);

    logic last_q;

    always_comb begin
        gnt_vld = |req;
        if (&req) gnt = ~last_q;
        else      gnt = req[PORT_B] ? PORT_B : PORT_A;
    end

    // Reset to B so that A wins the very first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)               last_q <= PORT_B;
        else if (en && gnt_vld)  last_q <= gnt;
    end

endmodule

// File: rtl/fazyrv_ram_arb.sv
// Round-robin arbiter and access sequencer for the single-port SoC RAM,
// emulating byte selects with read-modify-write.
//
// state | meaning
// IDLE  | arbitrate, latch the granted request
// RD    | RAM read of latched address (read or first half of RMW)
// RSP   | capture read data into the granted port's dat_o
// MERGE | combine RAM word with selected requester bytes
// WR    | RAM write of wdata register
// ACK   | one-cycle ack to granted port if its cyc is still high
module fazyrv_ram_arb
    import fazyrv_ram_arb_pkg::*;
#(
    parameter int ADRW   = 10,
    parameter bit RMW_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            a_cyc_i,
    input  logic            a_stb_i,
    input  logic            a_we_i,
    input  logic [ADRW-1:0] a_adr_i,
    input  logic [3:0]      a_sel_i,
    input  logic [31:0]     a_dat_i,
    output logic [31:0]     a_dat_o,
    output logic            a_ack_o,

    input  logic            b_cyc_i,
    input  logic            b_stb_i,
    input  logic            b_we_i,
    input  logic [ADRW-1:0] b_adr_i,
    input  logic [3:0]      b_sel_i,
    input  logic [31:0]     b_dat_i,
    output logic [31:0]     b_dat_o,
    output logic            b_ack_o,

    output logic            ram_we_o,
    output logic [ADRW-1:0] ram_waddr_o,
    output logic [ADRW-1:0] ram_raddr_o,
    output logic [31:0]     ram_wdata_o,
    input  logic [31:0]     ram_rdata_i
);

    state_t          state_q;
    logic            port_q;
    logic            we_q;
    logic [3:0]      sel_q;
    logic [ADRW-1:0] adr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     a_dat_q;
    logic [31:0]     b_dat_q;

    logic            gnt;
    logic            gnt_vld;
    logic            g_we;
    logic [ADRW-1:0] g_adr;
    logic [3:0]      g_sel;
    logic [31:0]     g_dat;
    logic            g_full;

    fazyrv_rr_arb2 u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     ({b_cyc_i & b_stb_i, a_cyc_i & a_stb_i}),
        .en      (state_q == S_IDLE),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        g_we   = (gnt == PORT_B) ? b_we_i  : a_we_i;
        g_adr  = (gnt == PORT_B) ? b_adr_i : a_adr_i;
        g_sel  = (gnt == PORT_B) ? b_sel_i : a_sel_i;
        g_dat  = (gnt == PORT_B) ? b_dat_i : a_dat_i;
        g_full = (g_sel == 4'hF) || (!RMW_EN && (g_sel != 4'h0));
    end

    // A write reaching RD is always the read half of an RMW.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            port_q  <= PORT_A;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= '0;
            wdata_q <= 32'h0;
            a_dat_q <= 32'h0;
            b_dat_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld) begin
                        port_q  <= gnt;
                        we_q    <= g_we;
                        sel_q   <= g_sel;
                        adr_q   <= g_adr;
                        wdata_q <= g_dat;
                        if (!g_we)                state_q <= S_RD;
                        else if (g_sel == 4'h0)   state_q <= S_ACK;
                        else if (g_full)          state_q <= S_WR;
                        else                      state_q <= S_RD;
                    end
                end
                S_RD:    state_q <= we_q ? S_MERGE : S_RSP;
                S_RSP: begin
                    if (port_q == PORT_B) b_dat_q <= ram_rdata_i;
                    else                  a_dat_q <= ram_rdata_i;
                    state_q <= S_ACK;
                end
                S_MERGE: begin
                    wdata_q <= byte_merge(ram_rdata_i, wdata_q, sel_q);
                    state_q <= S_WR;
                end
                S_WR:    state_q <= S_ACK;
                S_ACK:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ram_we_o    = (state_q == S_WR);
    assign ram_waddr_o = adr_q;
    assign ram_raddr_o = adr_q;
    assign ram_wdata_o = wdata_q;

    assign a_dat_o = a_dat_q;
    assign b_dat_o = b_dat_q;
    assign a_ack_o = (state_q == S_ACK) && (port_q == PORT_A) && a_cyc_i;
    assign b_ack_o = (state_q == S_ACK) && (port_q == PORT_B) && b_cyc_i;

endmodule

// File: tb/tb_fazyrv_ram_arb.sv
// Directed bench for fazyrv_ram_arb with a behavioural single-port RAM attached.
module tb_fazyrv_ram_arb;

    localparam int ADRW = 10;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            a_cyc_i, a_stb_i, a_we_i;
    logic [ADRW-1:0] a_adr_i;
    logic [3:0]      a_sel_i;
    logic [31:0]     a_dat_i, a_dat_o;
    logic            a_ack_o;
    logic            b_cyc_i, b_stb_i, b_we_i;
    logic [ADRW-1:0] b_adr_i;
    logic [3:0]      b_sel_i;
    logic [31:0]     b_dat_i, b_dat_o;
    logic            b_ack_o;
    logic            ram_we_o;
    logic [ADRW-1:0] ram_waddr_o, ram_raddr_o;
    logic [31:0]     ram_wdata_o;
    logic [31:0]     ram_rdata = 32'h0;

    logic [31:0] mem [0:(1<<ADRW)-1];
    int          we_cnt = 0;
    logic [31:0] last_wdata = 32'h0;
    int          total = 0;
    int          bad = 0;

    fazyrv_ram_arb #(.ADRW(ADRW), .RMW_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_cyc_i(a_cyc_i), .a_stb_i(a_stb_i), .a_we_i(a_we_i), .a_adr_i(a_adr_i),
        .a_sel_i(a_sel_i), .a_dat_i(a_dat_i), .a_dat_o(a_dat_o), .a_ack_o(a_ack_o),
        .b_cyc_i(b_cyc_i), .b_stb_i(b_stb_i), .b_we_i(b_we_i), .b_adr_i(b_adr_i),
        .b_sel_i(b_sel_i), .b_dat_i(b_dat_i), .b_dat_o(b_dat_o), .b_ack_o(b_ack_o),
        .ram_we_o(ram_we_o), .ram_waddr_o(ram_waddr_o), .ram_raddr_o(ram_raddr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (ram_we_o) mem[ram_waddr_o] <= ram_wdata_o;
        else          ram_rdata <= mem[ram_raddr_o];
    end

    always @(posedge clk_i) begin
        if (ram_we_o) begin
            we_cnt     <= we_cnt + 1;
            last_wdata <= ram_wdata_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    // Issues one request on a port and waits (bounded) for its ack; lat=-1 on timeout.
    task automatic xact(input logic port, input logic we, input logic [ADRW-1:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat,
                        output int lat, output logic [31:0] rd);
        if (port == 1'b0) begin
            a_cyc_i = 1'b1; a_stb_i = 1'b1; a_we_i = we; a_adr_i = adr; a_sel_i = sel; a_dat_i = dat;
        end else begin
            b_cyc_i = 1'b1; b_stb_i = 1'b1; b_we_i = we; b_adr_i = adr; b_sel_i = sel; b_dat_i = dat;
        end
        lat = -1;
        rd  = 32'h0;
        for (int n = 0; n < 12; n++) begin
            if ((port == 1'b0 && a_ack_o) || (port == 1'b1 && b_ack_o)) begin
                lat = n;
                rd  = (port == 1'b1) ? b_dat_o : a_dat_o;
                break;
            end
            @(posedge clk_i); #1;
        end
        if (port == 1'b0) begin a_cyc_i = 1'b0; a_stb_i = 1'b0; end
        else              begin b_cyc_i = 1'b0; b_stb_i = 1'b0; end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        a_cyc_i = 0; a_stb_i = 0; a_we_i = 0; a_adr_i = '0; a_sel_i = 0; a_dat_i = 0;
        b_cyc_i = 0; b_stb_i = 0; b_we_i = 0; b_adr_i = '0; b_sel_i = 0; b_dat_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        total++; if (ram_we_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", ram_we_o); end
        total++; if ({a_ack_o, b_ack_o} !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b exp=00", {a_ack_o, b_ack_o}); end
        total++; if (a_dat_o !== 32'h0) begin bad++; $display("FAIL reset_a_dat got=%h exp=0", a_dat_o); end
        total++; if (b_dat_o !== 32'h0) begin bad++; $display("FAIL reset_b_dat got=%h exp=0", b_dat_o); end
        total++; if (ram_raddr_o !== '0 || ram_waddr_o !== '0) begin bad++; $display("FAIL reset_addr got=%h/%h exp=0", ram_raddr_o, ram_waddr_o); end
        total++; if (ram_wdata_o !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", ram_wdata_o); end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_full_write_read();
        int lat;
        int w0;
        logic [31:0] rd;
        w0 = we_cnt;
        xact(1'b0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF, lat, rd);
        total++; if (lat !== 2) begin bad++; $display("FAIL full_wr_latency got=%0d exp=2", lat); end
        total++; if (we_cnt - w0 !== 1) begin bad++; $display("FAIL full_wr_pulses got=%0d exp=1", we_cnt - w0); end
        total++; if (mem[5] !== 32'hDEADBEEF) begin bad++; $display("FAIL full_wr_mem got=%h exp=deadbeef", mem[5]); end
        w0 = we_cnt;
        xact(1'b0, 1'b0, 10'd5, 4'hF, 32'h0, lat, rd);
        total++; if (lat !== 3) begin bad++; $display("FAIL rd_latency got=%0d exp=3", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        total++; if (we_cnt != w0) begin bad++; $display("FAIL rd_no_write got=%0d exp=0", we_cnt - w0); end
    endtask

    task automatic test_rmw();
        int lat;
        int w0;
        logic [31:0] rd;
        xact(1'b0, 1'b1, 10'd7, 4'hF, 32'h11223344, lat, rd);
        w0 = we_cnt;
        xact(1'b1, 1'b1, 10'd7, 4'b0101, 32'hAABBCCDD, lat, rd);
        total++; if (lat !== 4) begin bad++; $display("FAIL rmw_latency got=%0d exp=4", lat); end
        total++; if (we_cnt - w0 !== 1) begin bad++; $display("FAIL rmw_pulses got=%0d exp=1", we_cnt - w0); end
        total++; if (last_wdata !== 32'h11BB33DD) begin bad++; $display("FAIL rmw_wdata got=%h exp=11bb33dd", last_wdata); end
        total++; if (mem[7] !== 32'h11BB33DD) begin bad++; $display("FAIL rmw_mem got=%h exp=11bb33dd", mem[7]); end
        xact(1'b1, 1'b0, 10'd7, 4'hF, 32'h0, lat, rd);
        total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL rmw_readback got=%h exp=11bb33dd", rd); end
        total++; if (a_dat_o !== 32'hDEADBEEF) begin bad++; $display("FAIL a_dat_hold got=%h exp=deadbeef", a_dat_o); end
    endtask

    task automatic test_round_robin();
        int n;
        a_cyc_i = 1; a_stb_i = 1; a_we_i = 0; a_adr_i = 10'd7; a_sel_i = 4'hF;
        b_cyc_i = 1; b_stb_i = 1; b_we_i = 0; b_adr_i = 10'd5; b_sel_i = 4'hF;
        for (int t = 0; t < 8; t++) begin
            n = 0;
            while (!a_ack_o && !b_ack_o && n < 10) begin
                @(posedge clk_i); #1;
                n++;
            end
            total++; if ({a_ack_o, b_ack_o} !== ((t % 2 == 0) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_grant_%0d got=%b exp=%b", t, {a_ack_o, b_ack_o}, (t % 2 == 0) ? 2'b10 : 2'b01); end
            total++; if (n !== 3) begin bad++; $display("FAIL rr_latency_%0d got=%0d exp=3", t, n); end
            if (t % 2 == 0) begin
                total++; if (a_dat_o !== 32'h11BB33DD) begin bad++; $display("FAIL rr_a_dat_%0d got=%h exp=11bb33dd", t, a_dat_o); end
            end else begin
                total++; if (b_dat_o !== 32'hDEADBEEF) begin bad++; $display("FAIL rr_b_dat_%0d got=%h exp=deadbeef", t, b_dat_o); end
            end
            @(posedge clk_i); #1;
        end
        a_cyc_i = 0; a_stb_i = 0; b_cyc_i = 0; b_stb_i = 0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_sel_zero();
        int lat;
        int w0;
        logic [31:0] rd;
        xact(1'b0, 1'b1, 10'd3, 4'hF, 32'h00000055, lat, rd);
        w0 = we_cnt;
        xact(1'b0, 1'b1, 10'd3, 4'h0, 32'hFFFFFFFF, lat, rd);
        total++; if (lat !== 1) begin bad++; $display("FAIL sel0_latency got=%0d exp=1", lat); end
        total++; if (we_cnt != w0) begin bad++; $display("FAIL sel0_pulses got=%0d exp=0", we_cnt - w0); end
        total++; if (mem[3] !== 32'h00000055) begin bad++; $display("FAIL sel0_mem got=%h exp=00000055", mem[3]); end
    endtask

    task automatic test_cyc_drop();
        int lat;
        int w0;
        int n;
        int blat;
        logic a_seen;
        logic [31:0] rd;
        xact(1'b0, 1'b1, 10'd9, 4'hF, 32'hCAFEF00D, lat, rd);
        w0 = we_cnt;
        a_seen = 1'b0;
        a_cyc_i = 1; a_stb_i = 1; a_we_i = 1; a_adr_i = 10'd9; a_sel_i = 4'b0011; a_dat_i = 32'h12345678;
        @(posedge clk_i); #1;
        b_cyc_i = 1; b_stb_i = 1; b_we_i = 0; b_adr_i = 10'd3; b_sel_i = 4'hF;
        @(posedge clk_i); #1;
        a_cyc_i = 0; a_stb_i = 0;
        n = 2;
        blat = -1;
        while (n < 14) begin
            if (a_ack_o) a_seen = 1'b1;
            if (b_ack_o) begin
                blat = n;
                break;
            end
            @(posedge clk_i); #1;
            n++;
        end
        total++; if (a_seen !== 1'b0) begin bad++; $display("FAIL drop_a_ack got=%b exp=0", a_seen); end
        total++; if (we_cnt - w0 !== 1) begin bad++; $display("FAIL drop_pulses got=%0d exp=1", we_cnt - w0); end
        total++; if (mem[9] !== 32'hCAFE5678) begin bad++; $display("FAIL drop_mem got=%h exp=cafe5678", mem[9]); end
        total++; if (blat !== 8) begin bad++; $display("FAIL drop_b_latency got=%0d exp=8", blat); end
        total++; if (b_dat_o !== 32'h00000055) begin bad++; $display("FAIL drop_b_dat got=%h exp=00000055", b_dat_o); end
        b_cyc_i = 0; b_stb_i = 0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_mid_rmw();
        int lat;
        int w0;
        logic [31:0] rd;
        xact(1'b0, 1'b1, 10'd11, 4'hF, 32'h0F0F0F0F, lat, rd);
        w0 = we_cnt;
        a_cyc_i = 1; a_stb_i = 1; a_we_i = 1; a_adr_i = 10'd11; a_sel_i = 4'b0001; a_dat_i = 32'h000000FF;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        total++; if (ram_we_o !== 1'b0) begin bad++; $display("FAIL midrst_we got=%b exp=0", ram_we_o); end
        total++; if (ram_raddr_o !== '0 || ram_waddr_o !== '0) begin bad++; $display("FAIL midrst_addr got=%h/%h exp=0", ram_raddr_o, ram_waddr_o); end
        total++; if (ram_wdata_o !== 32'h0) begin bad++; $display("FAIL midrst_wdata got=%h exp=0", ram_wdata_o); end
        total++; if (a_dat_o !== 32'h0) begin bad++; $display("FAIL midrst_a_dat got=%h exp=0", a_dat_o); end
        total++; if (a_ack_o !== 1'b0) begin bad++; $display("FAIL midrst_ack got=%b exp=0", a_ack_o); end
        a_cyc_i = 0; a_stb_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        total++; if (we_cnt != w0) begin bad++; $display("FAIL midrst_pulses got=%0d exp=0", we_cnt - w0); end
        total++; if (mem[11] !== 32'h0F0F0F0F) begin bad++; $display("FAIL midrst_mem got=%h exp=0f0f0f0f", mem[11]); end
    endtask

    initial begin
        test_reset();
        test_full_write_read();
        test_rmw();
        test_round_robin();
        test_sel_zero();
        test_cyc_drop();
        test_reset_mid_rmw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
